// File: rtl/acc_mem_responder.sv
// acc_mem_responder
// Memory-side responder for the SHA-256 accelerator. It owns a word-wide
// backing store that is shared between a host (CPU) port and the accelerator.
// The accelerator reads 16-word lines and writes single words. Every committed
// host write is echoed on the listen bus so the accelerator can snoop it.
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   cpu_wr_en/cpu_rd_en        host write/read strobes (write wins on a tie)
//   cpu_addr, cpu_wr_data      host word address and write data
//   cpu_rd_data, cpu_rd_valid  host read data (held) and its one-cycle valid
//   acc_read_en/_addr          accelerator line-read request and start address
//   acc_read_data/_valid       assembled 512-bit line (word 0 in the MSBs) and valid pulse
//   acc_write_en/_addr/_data   accelerator word-write request
//   acc_write_done             one-cycle pulse after the write reaches the array
//   mem_listen_en/_addr/_data  registered echo of each committed host write
module acc_mem_responder #(
  parameter int DEPTH      = 65536,
  parameter int LINE_WORDS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_wr_en,
  input  logic         cpu_rd_en,
  input  logic [15:0]  cpu_addr,
  input  logic [31:0]  cpu_wr_data,
  output logic [31:0]  cpu_rd_data,
  output logic         cpu_rd_valid,
  input  logic         acc_read_en,
  input  logic [15:0]  acc_read_addr,
  output logic [511:0] acc_read_data,
  output logic         acc_read_data_valid,
  input  logic         acc_write_en,
  input  logic [15:0]  acc_write_addr,
  input  logic [31:0]  acc_write_data,
  output logic         acc_write_done,
  output logic         mem_listen_en,
  output logic [15:0]  mem_listen_addr,
  output logic [31:0]  mem_listen_data
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [4:0] LINE_CNT = 5'(LINE_WORDS);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [31:0] r_mem [DEPTH];

  logic [15:0] r_readAddr;
  logic [4:0]  r_beatCnt;
  logic [4:0]  r_capCnt;
  logic        r_beatRet;
  logic [31:0] r_beatData;

  logic        r_wrPending;
  logic [15:0] r_wrAddr;
  logic [31:0] r_wrData;

  logic        w_grantCpuRd;
  logic        w_grantAccWr;
  logic        w_grantBeat;
  logic        w_memWe;
  logic [15:0] w_addr;
  logic [31:0] w_wdata;
  logic [15:0] w_beatAddr;
  logic [ADDR_W-1:0] w_idx;

  // Beat addresses wrap naturally through the 16-bit adder.
  assign w_beatAddr = r_readAddr + {12'd0, r_beatCnt[3:0]};

  // Fixed-priority arbitration for the single array port:
  // host write > host read > pending accelerator write > next burst beat.
  always_comb begin
    w_grantCpuRd = cpu_rd_en && !cpu_wr_en;
    w_grantAccWr = r_wrPending && !cpu_wr_en && !cpu_rd_en;
    w_grantBeat  = (r_state == BURST) && (r_beatCnt < LINE_CNT) &&
                   !cpu_wr_en && !cpu_rd_en && !r_wrPending;
    w_addr       = w_beatAddr;
    w_wdata      = r_wrData;
    w_memWe      = 1'b0;
    if (cpu_wr_en || cpu_rd_en) begin
      w_addr = cpu_addr;
    end else if (w_grantAccWr) begin
      w_addr = r_wrAddr;
    end
    if (cpu_wr_en) begin
      w_wdata = cpu_wr_data;
      w_memWe = 1'b1;
    end else if (w_grantAccWr) begin
      w_memWe = 1'b1;
    end
  end

  assign w_idx = w_addr[ADDR_W-1:0];

  // Backing store and beat read register; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_idx] <= w_wdata;
    end
    if (w_grantBeat) begin
      r_beatData <= r_mem[w_idx];
    end
  end

  // Host read data lands the cycle after issue and holds until the next host read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rd_data  <= 32'd0;
      cpu_rd_valid <= 1'b0;
    end else begin
      cpu_rd_valid <= w_grantCpuRd;
      if (w_grantCpuRd) begin
        cpu_rd_data <= r_mem[w_idx];
      end
    end
  end

  // Listen bus echoes host writes only; accelerator writes stay silent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_listen_en   <= 1'b0;
      mem_listen_addr <= 16'd0;
      mem_listen_data <= 32'd0;
    end else begin
      mem_listen_en <= cpu_wr_en;
      if (cpu_wr_en) begin
        mem_listen_addr <= cpu_addr;
        mem_listen_data <= cpu_wr_data;
      end
    end
  end

  // A single-entry accelerator write buffer; new requests are ignored while it is full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPending    <= 1'b0;
      r_wrAddr       <= 16'd0;
      r_wrData       <= 32'd0;
      acc_write_done <= 1'b0;
    end else begin
      acc_write_done <= w_grantAccWr;
      if (r_wrPending) begin
        if (w_grantAccWr) begin
          r_wrPending <= 1'b0;
        end
      end else if (acc_write_en) begin
        r_wrPending <= 1'b1;
        r_wrAddr    <= acc_write_addr;
        r_wrData    <= acc_write_data;
      end
    end
  end

  // Burst bookkeeping: beats issued vs. words captured. Captured words shift
  // in from the bottom so the first word ends up in the top slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_readAddr    <= 16'd0;
      r_beatCnt     <= 5'd0;
      r_capCnt      <= 5'd0;
      r_beatRet     <= 1'b0;
      acc_read_data <= 512'd0;
    end else begin
      r_state   <= w_stateNext;
      r_beatRet <= w_grantBeat;
      if (r_state == IDLE && acc_read_en) begin
        r_readAddr <= acc_read_addr;
        r_beatCnt  <= 5'd0;
        r_capCnt   <= 5'd0;
      end else begin
        if (w_grantBeat) begin
          r_beatCnt <= r_beatCnt + 5'd1;
        end
        if (r_beatRet) begin
          r_capCnt      <= r_capCnt + 5'd1;
          acc_read_data <= {acc_read_data[479:0], r_beatData};
        end
      end
    end
  end

  // Next-state and line-valid decode for the read burst.
  always_comb begin
    w_stateNext         = r_state;
    acc_read_data_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (acc_read_en) begin
          w_stateNext = BURST;
        end
      end
      BURST: begin
        if (r_beatRet && (r_capCnt == LINE_CNT - 5'd1)) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        acc_read_data_valid = 1'b1;
        w_stateNext         = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_acc_mem_responder.sv
// tb_acc_mem_responder
// Directed bench for acc_mem_responder. Stimulus pushes expected responses
// (data plus the cycle they must appear in) into queues; a monitor on the
// falling edge pops and compares whenever the DUT raises a valid-type output.
module tb_acc_mem_responder;

  logic         clk;
  logic         rst_n;
  logic         cpu_wr_en;
  logic         cpu_rd_en;
  logic [15:0]  cpu_addr;
  logic [31:0]  cpu_wr_data;
  logic [31:0]  cpu_rd_data;
  logic         cpu_rd_valid;
  logic         acc_read_en;
  logic [15:0]  acc_read_addr;
  logic [511:0] acc_read_data;
  logic         acc_read_data_valid;
  logic         acc_write_en;
  logic [15:0]  acc_write_addr;
  logic [31:0]  acc_write_data;
  logic         acc_write_done;
  logic         mem_listen_en;
  logic [15:0]  mem_listen_addr;
  logic [31:0]  mem_listen_data;

  acc_mem_responder dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cpu_wr_en           (cpu_wr_en),
    .cpu_rd_en           (cpu_rd_en),
    .cpu_addr            (cpu_addr),
    .cpu_wr_data         (cpu_wr_data),
    .cpu_rd_data         (cpu_rd_data),
    .cpu_rd_valid        (cpu_rd_valid),
    .acc_read_en         (acc_read_en),
    .acc_read_addr       (acc_read_addr),
    .acc_read_data       (acc_read_data),
    .acc_read_data_valid (acc_read_data_valid),
    .acc_write_en        (acc_write_en),
    .acc_write_addr      (acc_write_addr),
    .acc_write_data      (acc_write_data),
    .acc_write_done      (acc_write_done),
    .mem_listen_en       (mem_listen_en),
    .mem_listen_addr     (mem_listen_addr),
    .mem_listen_data     (mem_listen_data)
  );

  typedef struct packed { logic [31:0] data; logic [31:0] cyc; } wordExp_t;
  typedef struct packed { logic [15:0] addr; logic [31:0] data; logic [31:0] cyc; } listenExp_t;
  typedef struct packed { logic [511:0] line; logic [31:0] cyc; } lineExp_t;

  wordExp_t    cpuRdQ[$];
  listenExp_t  listenQ[$];
  lineExp_t    lineQ[$];
  logic [31:0] doneQ[$];

  int          vectors;
  int          miscompares;
  logic [31:0] cyc;

  // Free-running clock and cycle counter; inputs change #1 after a rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic checkOutput(input string name, input logic [511:0] actual,
                             input logic [511:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic unexpectedPulse(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got pulse 1 expected 0 (nothing queued)", name);
  endtask

  // Monitor: every valid-type pulse must match the head of its queue, in data and cycle.
  always @(negedge clk) begin
    if (cpu_rd_valid) begin
      if (cpuRdQ.size() == 0) unexpectedPulse("cpu_rd_valid");
      else begin
        wordExp_t e;
        e = cpuRdQ.pop_front();
        checkOutput("cpu_rd_data", 512'(cpu_rd_data), 512'(e.data));
        checkOutput("cpu_rd_cycle", 512'(cyc), 512'(e.cyc));
      end
    end
    if (mem_listen_en) begin
      if (listenQ.size() == 0) unexpectedPulse("mem_listen_en");
      else begin
        listenExp_t e;
        e = listenQ.pop_front();
        checkOutput("listen_addr", 512'(mem_listen_addr), 512'(e.addr));
        checkOutput("listen_data", 512'(mem_listen_data), 512'(e.data));
        checkOutput("listen_cycle", 512'(cyc), 512'(e.cyc));
      end
    end
    if (acc_write_done) begin
      if (doneQ.size() == 0) unexpectedPulse("acc_write_done");
      else begin
        logic [31:0] e;
        e = doneQ.pop_front();
        checkOutput("write_done_cycle", 512'(cyc), 512'(e));
      end
    end
    if (acc_read_data_valid) begin
      if (lineQ.size() == 0) unexpectedPulse("acc_read_data_valid");
      else begin
        lineExp_t e;
        e = lineQ.pop_front();
        checkOutput("acc_read_data", acc_read_data, e.line);
        checkOutput("line_valid_cycle", 512'(cyc), 512'(e.cyc));
      end
    end
  end

  // Drive one cycle of inputs, queue host-side expectations, then release strobes.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdExp,
                               input logic accRd, input logic [15:0] accRdAddr,
                               input logic accWr, input logic [15:0] accWrAddr,
                               input logic [31:0] accWrData);
    cpu_wr_en      = wr;
    cpu_rd_en      = rd;
    cpu_addr       = addr;
    cpu_wr_data    = wdata;
    acc_read_en    = accRd;
    acc_read_addr  = accRdAddr;
    acc_write_en   = accWr;
    acc_write_addr = accWrAddr;
    acc_write_data = accWrData;
    if (wr) listenQ.push_back('{addr: addr, data: wdata, cyc: cyc + 32'd1});
    if (rd && !wr) cpuRdQ.push_back('{data: rdExp, cyc: cyc + 32'd1});
    @(posedge clk);
    #1;
    cpu_wr_en    = 1'b0;
    cpu_rd_en    = 1'b0;
    acc_read_en  = 1'b0;
    acc_write_en = 1'b0;
  endtask

  task automatic hostWrite(input logic [15:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, a, d, 32'd0, 1'b0, 16'd0, 1'b0, 16'd0, 32'd0);
  endtask

  task automatic hostRead(input logic [15:0] a, input logic [31:0] expd);
    applyStimulus(1'b0, 1'b1, a, 32'd0, expd, 1'b0, 16'd0, 1'b0, 16'd0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b0, 16'd0, 1'b0, 16'd0, 32'd0);
  endtask

  // Line whose word i is base+i, word 0 in the top slot.
  function automatic logic [511:0] buildLine(input logic [31:0] base);
    logic [511:0] l;
    l = '0;
    for (int i = 0; i < 16; i++) l[511 - 32*i -: 32] = base + 32'(i);
    return l;
  endfunction

  // Wait (bounded) until every expected response has been seen.
  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while ((cpuRdQ.size() + listenQ.size() + lineQ.size() + doneQ.size()) != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if ((cpuRdQ.size() + listenQ.size() + lineQ.size() + doneQ.size()) != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: timed out, outstanding %0d expected 0", name,
               cpuRdQ.size() + listenQ.size() + lineQ.size() + doneQ.size());
      cpuRdQ.delete();
      listenQ.delete();
      lineQ.delete();
      doneQ.delete();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] t;
    logic [15:0] a;
    logic [511:0] l;
    vectors     = 0;
    miscompares = 0;
    cyc         = 32'd0;
    rst_n       = 1'b0;
    cpu_wr_en = 1'b0; cpu_rd_en = 1'b0; cpu_addr = 16'd0; cpu_wr_data = 32'd0;
    acc_read_en = 1'b0; acc_read_addr = 16'd0;
    acc_write_en = 1'b0; acc_write_addr = 16'd0; acc_write_data = 32'd0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst cpu_rd_valid", 512'(cpu_rd_valid), 512'd0);
    checkOutput("rst cpu_rd_data", 512'(cpu_rd_data), 512'd0);
    checkOutput("rst acc_read_data", acc_read_data, 512'd0);
    checkOutput("rst acc_read_data_valid", 512'(acc_read_data_valid), 512'd0);
    checkOutput("rst acc_write_done", 512'(acc_write_done), 512'd0);
    checkOutput("rst mem_listen_en", 512'(mem_listen_en), 512'd0);
    rst_n = 1'b1;
    idle(2);

    // Preload line 0x1000 with 0x10000000+i
    $display("[TB] preload 0x1000 line");
    for (int i = 0; i < 16; i++) hostWrite(16'h1000 + 16'(i), 32'h1000_0000 + 32'(i));
    waitDrain("preload 1000", 10);

    // Reset in the middle of a burst: no valid, line register cleared
    $display("[TB] reset mid-burst");
    applyStimulus(1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1, 16'h1000, 1'b0, 16'd0, 32'd0);
    idle(4);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    checkOutput("midburst acc_read_data", acc_read_data, 512'd0);
    idle(25);
    t = cyc;
    lineQ.push_back('{line: buildLine(32'h1000_0000), cyc: t + 32'd18});
    applyStimulus(1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1, 16'h1000, 1'b0, 16'd0, 32'd0);
    waitDrain("line 1000 after reset", 40);

    // Uncontended line read at 0x5000
    $display("[TB] preload and read 0x5000 line");
    for (int i = 0; i < 16; i++) hostWrite(16'h5000 + 16'(i), 32'(i));
    t = cyc;
    lineQ.push_back('{line: buildLine(32'h0), cyc: t + 32'd18});
    applyStimulus(1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1, 16'h5000, 1'b0, 16'd0, 32'd0);
    waitDrain("line 5000", 40);

    // Same read, three host reads steal three cycles
    $display("[TB] line read with host contention");
    t = cyc;
    lineQ.push_back('{line: buildLine(32'h0), cyc: t + 32'd21});
    applyStimulus(1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1, 16'h5000, 1'b0, 16'd0, 32'd0);
    idle(2);
    hostRead(16'h5001, 32'h1);
    hostRead(16'h5002, 32'h2);
    hostRead(16'h5003, 32'h3);
    waitDrain("contended line 5000", 40);

    // Accelerator write: done two cycles after request, not broadcast
    $display("[TB] accelerator write 0x1004");
    t = cyc;
    doneQ.push_back(t + 32'd2);
    applyStimulus(1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b0, 16'd0, 1'b1, 16'h1004, 32'hDEADBEEF);
    idle(2);
    hostRead(16'h1004, 32'hDEADBEEF);
    waitDrain("acc write 1004", 10);

    // Read and write requests together; second read request mid-burst ignored
    $display("[TB] read+write same cycle");
    l = buildLine(32'h1000_0000);
    l[511 - 32*4  -: 32] = 32'hDEADBEEF;
    l[511 - 32*10 -: 32] = 32'hCAFEF00D;
    t = cyc;
    doneQ.push_back(t + 32'd2);
    lineQ.push_back('{line: l, cyc: t + 32'd19});
    applyStimulus(1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1, 16'h1000, 1'b1, 16'h100A, 32'hCAFEF00D);
    idle(3);
    applyStimulus(1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1, 16'h5000, 1'b0, 16'd0, 32'd0);
    waitDrain("read+write hazard", 40);
    idle(25);

    // Wrap-around burst starting at 0xFFF8
    $display("[TB] wrap burst 0xFFF8");
    for (int i = 0; i < 16; i++) begin
      a = 16'hFFF8 + 16'(i);
      hostWrite(a, 32'h0000_F000 + 32'(i));
    end
    t = cyc;
    lineQ.push_back('{line: buildLine(32'h0000_F000), cyc: t + 32'd18});
    applyStimulus(1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1, 16'hFFF8, 1'b0, 16'd0, 32'd0);
    waitDrain("wrap line", 40);

    // Host write and read together: write wins, read dropped
    $display("[TB] host write+read collision");
    applyStimulus(1'b1, 1'b1, 16'h2000, 32'h12345678, 32'd0, 1'b0, 16'd0, 1'b0, 16'd0, 32'd0);
    idle(2);
    hostRead(16'h2000, 32'h12345678);
    waitDrain("wr+rd collision", 10);
    idle(3);

    checkOutput("queues drained", 512'(cpuRdQ.size() + listenQ.size() + lineQ.size() + doneQ.size()), 512'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/acc_mem_responder.md
Name: acc_mem_responder

Overview:
- Memory-side responder serving the SHA-256 accelerator's memory interface.
- Owns a 32-bit-word backing store shared by a host (CPU) port and the accelerator.
- Accelerator line reads return 512-bit lines of 16 consecutive words; accelerator word writes are acknowledged with a done pulse.
- Host writes are broadcast on the listen bus so the accelerator can snoop its control blocks.

Parameters:
DEPTH, 65536, number of 32-bit words in the backing store; index = addr[$clog2(DEPTH)-1:0]
LINE_WORDS, 16, words per accelerator line read; fixed at 16 (512 bits)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
cpu_wr_en  input  1  host write strobe
cpu_rd_en  input  1  host read strobe
cpu_addr  input  16  host word address
cpu_wr_data  input  32  host write data
cpu_rd_data  output  32  host read data
cpu_rd_valid  output  1  one-cycle pulse, cpu_rd_data valid
acc_read_en  input  1  accelerator line-read request pulse
acc_read_addr  input  16  starting word address of the line
acc_read_data  output  512  assembled line; word at addr+0 in [511:480], addr+15 in [31:0]
acc_read_data_valid  output  1  one-cycle pulse, line complete
acc_write_en  input  1  accelerator word-write request pulse
acc_write_addr  input  16  word address
acc_write_data  input  32  write data
acc_write_done  output  1  one-cycle pulse, write committed
mem_listen_en  output  1  one-cycle pulse per committed host write
mem_listen_addr  output  16  address of that write
mem_listen_data  output  32  data of that write

Behaviour:
- Single-port synchronous array: one access per cycle; read data is available the cycle after issue. Memory contents are not reset.
- Reset: all outputs 0, pending flags and burst state cleared. Reset mid-burst or mid-write abandons the operation with no done/valid pulse. A write already committed to the array stays.
- Port arbitration, each cycle, in priority order:
  1. Host write (cpu_wr_en).
  2. Host read (cpu_rd_en). If host write and read are asserted together, the write wins and the read is dropped.
  3. Pending accelerator write.
  4. Next beat of an active accelerator read burst.
- The accelerator can be starved indefinitely by continuous host traffic.
- Host read: issued cycle C, cpu_rd_data/cpu_rd_valid in C+1; cpu_rd_data holds until the next host read.
- Host write: committed at the end of cycle C; mem_listen_en=1 with registered addr/data in C+1. Accelerator writes are never broadcast.
- Accelerator request acceptance:
  - acc_write_en is latched (addr/data captured) when no accelerator write is pending; otherwise ignored.
  - acc_read_en is latched when no burst is active; otherwise ignored.
  - Read and write requests in the same cycle are both latched.
- Accelerator write: when granted in cycle C, the array is written at the end of C and acc_write_done=1 in C+1.
- Read burst FSM, states IDLE -> BURST -> DONE -> IDLE:
  - BURST issues beats k=0..15 at address (acc_read_addr+k) mod 2^16, and only on cycles it wins the port.
  - The returned word k is shifted into acc_read_data word slot k.
  - After the 16th word is captured, the FSM enters DONE: acc_read_data_valid=1 for one cycle, then IDLE.
  - acc_read_data holds until the next line's first word is captured.
- Latency with no contention: request at cycle T -> beats issued T+1..T+16 -> acc_read_data_valid in T+18. Each stolen cycle adds 1.
- Hazards:
  - A pending accelerator write outranks remaining burst beats, so later beats observe it.
  - A host write to an address whose beat is already issued is not reflected in the line.
- Address wrap: a burst starting at 16'hFFF8 reads FFF8..FFFF then 0000..0007.

Test Plan:
- Reset mid-burst: acc_read_en at 16'h1000, assert rst_n=0 at T+5 -> no acc_read_data_valid; acc_read_data=0; next request returns a correct line.
- Preload words 16'h5000..500F = 32'h0..32'hF via host, acc_read_en addr 16'h5000 at T -> valid only at T+18; acc_read_data = {32'h0,32'h1,...,32'hF}; 16 mem_listen pulses observed during preload.
- Same read with cpu_rd_en asserted for 3 cycles during the burst -> valid at T+21; data unchanged; 3 cpu_rd_valid pulses with correct data.
- acc_write_en addr 16'h1004 data 32'hDEADBEEF -> acc_write_done one cycle after grant; no mem_listen pulse; host read of 16'h1004 returns DEADBEEF.
- acc_read_en and acc_write_en to 16'h100A same cycle -> line word 10 = new write data; write_done precedes read valid; a second acc_read_en mid-burst is ignored (exactly one valid pulse).
- Wrap and conflicts: burst at 16'hFFF8 -> words FFF8..0007 in order. cpu_wr_en+cpu_rd_en together -> write commits, no cpu_rd_valid, listen pulse with addr/data.
